// File: rtl/echo_req_scheduler.sv
// Shares one Echo block among NREQ requesters: round-robin request arbitration,
// a tag FIFO recording who asked, and one-at-a-time response routing back to them.
module echo_req_scheduler #(
    parameter  int NREQ      = 4,
    parameter  int DW        = 32,
    parameter  int TAG_DEPTH = 4,
    localparam int TW        = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int OW        = (TW + 1 < 3) ? 3 : TW + 1
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NREQ-1:0]    req__ENA,
    input  logic [NREQ*DW-1:0] req_v,
    output logic [NREQ-1:0]    req__RDY,
    output logic [NREQ-1:0]    rsp__ENA,
    output logic [DW-1:0]      rsp_v,
    input  logic [NREQ-1:0]    rsp__RDY,
    output logic               echo_echoReq__ENA,
    output logic [DW-1:0]      echo_echoReq_v,
    input  logic               echo_echoReq__RDY,
    output logic               echo_rule_respond__ENA,
    input  logic               echo_rule_respond__RDY,
    input  logic               echo_ind_echo__ENA,
    input  logic [DW-1:0]      echo_ind_echo_v,
    output logic [OW-1:0]      outstanding,
    output logic               err
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_HOLD = 2'd2
    } rsp_state_t;

    rsp_state_t      r_state, w_state_nxt;
    logic [TW-1:0]   r_rr_ptr;
    logic [TW-1:0]   r_tags [TAG_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_hold_tag;
    logic [DW-1:0]   r_hold_v;
    logic            r_err;

    logic            w_full, w_empty;
    logic [NREQ-1:0] w_cand;
    logic            w_grant_vld;
    logic [TW-1:0]   w_grant_idx;
    logic [TW-1:0]   w_rr_next;
    logic            w_push, w_pop;
    logic            w_fire, w_accept, w_ind_err;

    assign w_full  = (r_count == CW'(TAG_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_cand  = req__ENA & {NREQ{echo_echoReq__RDY & ~w_full}};

    // First candidate at or after the round-robin pointer, wrapping past NREQ-1.
    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_grant_vld && w_cand[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = TW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    assign req__RDY          = w_grant_vld ? (NREQ'(1) << w_grant_idx) : '0;
    assign echo_echoReq__ENA = |(req__ENA & req__RDY);
    assign echo_echoReq_v    = req_v[int'(w_grant_idx)*DW +: DW];
    assign w_push            = echo_echoReq__ENA;
    assign w_rr_next         = (w_grant_idx == TW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // An indication is legal in WAIT, or in the very cycle rule_respond fires.
    assign w_fire    = (r_state == RSP_IDLE) & echo_rule_respond__RDY & ~w_empty;
    assign w_accept  = echo_ind_echo__ENA & ((r_state == RSP_WAIT) | w_fire);
    assign w_ind_err = echo_ind_echo__ENA & ~w_accept;
    assign w_pop     = w_accept;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= RSP_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RSP_IDLE: if (w_fire) w_state_nxt = w_accept ? RSP_HOLD : RSP_WAIT;
            RSP_WAIT: if (w_accept) w_state_nxt = RSP_HOLD;
            RSP_HOLD: if (rsp__RDY[r_hold_tag]) w_state_nxt = RSP_IDLE;
            default:  w_state_nxt = RSP_IDLE;
        endcase
    end

    always_comb begin
        echo_rule_respond__ENA = w_fire;
        rsp__ENA               = (r_state == RSP_HOLD) ? (NREQ'(1) << r_hold_tag) : '0;
        rsp_v                  = r_hold_v;
    end

    // NOTE: the tag array has no reset; occupancy and pointers alone decide
    // which entries are meaningful, so clearing storage would buy nothing.
    always_ff @(posedge CLK) begin
        if (w_push) r_tags[r_wr_ptr] <= w_grant_idx;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hold_tag <= '0;
            r_hold_v   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_rr_next;
                r_wr_ptr <= (r_wr_ptr == PW'(TAG_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_hold_tag <= r_tags[r_rd_ptr];
                r_hold_v   <= echo_ind_echo_v;
                r_rd_ptr   <= (r_rd_ptr == PW'(TAG_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_ind_err) r_err <= 1'b1;
        end
    end

    assign outstanding = OW'(r_count);
    assign err         = r_err;

endmodule

// File: tb/tb_echo_req_scheduler.sv
// Directed bench for echo_req_scheduler: the bench plays both the requesters and
// the Echo block, with hand-computed expectations at each step.
module tb_echo_req_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic               CLK = 1'b0;
    logic               nRST;
    logic [NREQ-1:0]    req__ENA;
    logic [NREQ*DW-1:0] req_v;
    logic [NREQ-1:0]    req__RDY;
    logic [NREQ-1:0]    rsp__ENA;
    logic [DW-1:0]      rsp_v;
    logic [NREQ-1:0]    rsp__RDY;
    logic               echo_echoReq__ENA;
    logic [DW-1:0]      echo_echoReq_v;
    logic               echo_echoReq__RDY;
    logic               echo_rule_respond__ENA;
    logic               echo_rule_respond__RDY;
    logic               echo_ind_echo__ENA;
    logic [DW-1:0]      echo_ind_echo_v;
    logic [2:0]         outstanding;
    logic               err;

    int n_vec  = 0;
    int n_miss = 0;

    echo_req_scheduler #(.NREQ(NREQ), .DW(DW), .TAG_DEPTH(4)) dut (
        .CLK                    (CLK),
        .nRST                   (nRST),
        .req__ENA               (req__ENA),
        .req_v                  (req_v),
        .req__RDY               (req__RDY),
        .rsp__ENA               (rsp__ENA),
        .rsp_v                  (rsp_v),
        .rsp__RDY               (rsp__RDY),
        .echo_echoReq__ENA      (echo_echoReq__ENA),
        .echo_echoReq_v         (echo_echoReq_v),
        .echo_echoReq__RDY      (echo_echoReq__RDY),
        .echo_rule_respond__ENA (echo_rule_respond__ENA),
        .echo_rule_respond__RDY (echo_rule_respond__RDY),
        .echo_ind_echo__ENA     (echo_ind_echo__ENA),
        .echo_ind_echo_v        (echo_ind_echo_v),
        .outstanding            (outstanding),
        .err                    (err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start in IDLE with a non-empty FIFO; fire, deliver the indication a cycle
    // later, check the routed response, then release it.
    task automatic drain_one(input int tag, input logic [DW-1:0] v);
        echo_rule_respond__RDY = 1'b1;
        #1;
        check("drain_fire", echo_rule_respond__ENA, 1);
        step();
        #1;
        check("wait_no_fire", echo_rule_respond__ENA, 0);
        echo_ind_echo__ENA = 1'b1;
        echo_ind_echo_v    = v;
        step();
        echo_ind_echo__ENA = 1'b0;
        #1;
        check("drain_rsp_ena", rsp__ENA, 64'(4'b0001 << tag));
        check("drain_rsp_v", rsp_v, v);
        check("hold_no_fire", echo_rule_respond__ENA, 0);
        rsp__RDY = 4'(4'b0001 << tag);
        step();
        rsp__RDY = '0;
        echo_rule_respond__RDY = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        req__ENA = '0;
        req_v = '0;
        rsp__RDY = '0;
        echo_echoReq__RDY = 1'b1;
        echo_rule_respond__RDY = 1'b1;
        echo_ind_echo__ENA = 1'b0;
        echo_ind_echo_v = '0;
        for (int k = 0; k < NREQ; k++) req_v[k*DW +: DW] = 32'hC0DE_0000 | 32'(k);

        // Reset state
        step();
        step();
        nRST = 1'b1;
        #1;
        check("rst_req_rdy", req__RDY, 0);
        check("rst_rsp_ena", rsp__ENA, 0);
        check("rst_echoreq_ena", echo_echoReq__ENA, 0);
        check("rst_rule_ena", echo_rule_respond__ENA, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err, 0);
        echo_rule_respond__RDY = 1'b0;

        // Fairness, first batch, until the tag FIFO fills
        req__ENA = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fair1_grant", req__RDY, 64'(4'b0001 << k));
            check("fair1_v", echo_echoReq_v, 32'hC0DE_0000 | 32'(k));
            step();
        end
        #1;
        check("full_req_rdy", req__RDY, 0);
        check("full_echoreq_ena", echo_echoReq__ENA, 0);
        check("full_outstanding", outstanding, 4);
        step();
        #1;
        check("full_still_blocked", req__RDY, 0);

        // Releasing one response frees a slot and requests resume at requester 0
        echo_rule_respond__RDY = 1'b1;
        step();
        echo_rule_respond__RDY = 1'b0;
        echo_ind_echo__ENA = 1'b1;
        echo_ind_echo_v = 32'h0000_0100;
        req__ENA = '0;
        step();
        echo_ind_echo__ENA = 1'b0;
        #1;
        check("bp_rsp_ena", rsp__ENA, 4'b0001);
        check("bp_outstanding", outstanding, 3);
        rsp__RDY = 4'b0001;
        step();
        rsp__RDY = '0;
        for (int k = 1; k < 4; k++) drain_one(k, 32'h0000_0100 | 32'(k));
        #1;
        check("drained_outstanding", outstanding, 0);

        // Fairness, second batch continues the rotation
        req__ENA = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fair2_grant", req__RDY, 64'(4'b0001 << k));
            step();
        end
        req__ENA = '0;
        for (int k = 0; k < 4; k++) drain_one(k, 32'h0000_0200 | 32'(k));

        // Single requester, with response held until the right rsp__RDY bit
        req_v[2*DW +: DW] = 32'h0000_00A5;
        req__ENA = 4'b0100;
        #1;
        check("single_grant", req__RDY, 4'b0100);
        check("single_echo_ena", echo_echoReq__ENA, 1);
        check("single_echo_v", echo_echoReq_v, 32'h0000_00A5);
        step();
        req__ENA = '0;
        echo_rule_respond__RDY = 1'b1;
        #1;
        check("single_outstanding", outstanding, 1);
        check("single_fire", echo_rule_respond__ENA, 1);
        step();
        echo_ind_echo__ENA = 1'b1;
        echo_ind_echo_v = 32'h0000_00A5;
        step();
        echo_ind_echo__ENA = 1'b0;
        rsp__RDY = 4'b1011;
        #1;
        check("single_rsp_ena", rsp__ENA, 4'b0100);
        check("single_rsp_v", rsp_v, 32'h0000_00A5);
        step();
        #1;
        check("single_rsp_held", rsp__ENA, 4'b0100);
        rsp__RDY = 4'b0100;
        step();
        rsp__RDY = '0;
        echo_rule_respond__RDY = 1'b0;
        #1;
        check("single_released", rsp__ENA, 0);
        check("single_err", err, 0);

        // Ordering: 3 then 1; a new request pushes while the first indication pops
        req_v[3*DW +: DW] = 32'h0000_0011;
        req_v[1*DW +: DW] = 32'h0000_0022;
        req_v[0*DW +: DW] = 32'h0000_0033;
        req__ENA = 4'b1000;
        #1;
        check("ord_grant3", req__RDY, 4'b1000);
        step();
        req__ENA = 4'b0010;
        #1;
        check("ord_grant1", req__RDY, 4'b0010);
        step();
        req__ENA = '0;
        echo_rule_respond__RDY = 1'b1;
        step();
        echo_rule_respond__RDY = 1'b0;
        echo_ind_echo__ENA = 1'b1;
        echo_ind_echo_v = 32'h0000_0011;
        req__ENA = 4'b0001;
        #1;
        check("ord_push_grant0", req__RDY, 4'b0001);
        step();
        echo_ind_echo__ENA = 1'b0;
        req__ENA = '0;
        #1;
        check("ord_pushpop_outstanding", outstanding, 2);
        check("ord_rsp3_ena", rsp__ENA, 4'b1000);
        check("ord_rsp3_v", rsp_v, 32'h0000_0011);
        rsp__RDY = 4'b1000;
        step();
        rsp__RDY = '0;
        drain_one(1, 32'h0000_0022);

        // Indication in the same cycle as the fire is accepted, not an error
        echo_rule_respond__RDY = 1'b1;
        echo_ind_echo__ENA = 1'b1;
        echo_ind_echo_v = 32'h0000_0033;
        #1;
        check("same_cycle_fire", echo_rule_respond__ENA, 1);
        step();
        echo_rule_respond__RDY = 1'b0;
        echo_ind_echo__ENA = 1'b0;
        #1;
        check("same_cycle_rsp_ena", rsp__ENA, 4'b0001);
        check("same_cycle_rsp_v", rsp_v, 32'h0000_0033);
        check("same_cycle_err", err, 0);
        check("same_cycle_outstanding", outstanding, 0);
        rsp__RDY = 4'b0001;
        step();
        rsp__RDY = '0;

        // Protocol error: stray indication in IDLE with an empty FIFO
        echo_ind_echo__ENA = 1'b1;
        echo_ind_echo_v = 32'h0000_DEAD;
        #1;
        check("perr_before", err, 0);
        step();
        echo_ind_echo__ENA = 1'b0;
        #1;
        check("perr_err", err, 1);
        check("perr_outstanding", outstanding, 0);
        check("perr_rsp_ena", rsp__ENA, 0);
        step();
        #1;
        check("perr_sticky", err, 1);

        // Reset mid-flight: tags 1,2,1 queued, first popped into HOLD
        req__ENA = 4'b0110;
        #1;
        check("mid_grant1", req__RDY, 4'b0010);
        step();
        #1;
        check("mid_grant2", req__RDY, 4'b0100);
        step();
        req__ENA = 4'b0010;
        #1;
        check("mid_grant1b", req__RDY, 4'b0010);
        step();
        req__ENA = '0;
        echo_rule_respond__RDY = 1'b1;
        echo_ind_echo__ENA = 1'b1;
        echo_ind_echo_v = 32'h0000_0077;
        step();
        echo_rule_respond__RDY = 1'b0;
        echo_ind_echo__ENA = 1'b0;
        #1;
        check("mid_hold_ena", rsp__ENA, 4'b0010);
        check("mid_outstanding", outstanding, 2);
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        echo_rule_respond__RDY = 1'b1;
        req__ENA = 4'b1111;
        #1;
        check("mid_rst_rsp_ena", rsp__ENA, 0);
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rule_ena", echo_rule_respond__ENA, 0);
        check("mid_rst_rr_ptr", req__RDY, 4'b0001);
        req__ENA = '0;
        echo_rule_respond__RDY = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
